// File: rtl/lfsr_arb.sv
// lfsr_arb -- shares one Fibonacci LFSR between two requesters.
//
// Each granted draw advances the LFSR DRAW steps and returns the final value as
// a fresh random word. Round-robin arbitration picks the winner when both
// requesters are up. A seed can be loaded while idle; a zero seed is replaced by
// RESET_SEED and flagged, because an all-zero LFSR would never leave zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   seed_load  load seed (honoured in IDLE only, wins over req)
//   seed       seed value
//   req        level requests; hold until gnt is seen, then drop
//   gnt        one-hot grant, high only together with rnd_valid
//   rnd_valid  one-cycle pulse, rnd is valid for the gnt owner
//   rnd        random word, held until the next completed draw
//   busy       high while a draw is in progress (STEP and DONE)
//   seed_err   one-cycle pulse: zero seed replaced by RESET_SEED
module lfsr_arb #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'b0001,
  parameter int               DRAW       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd,
  output logic             busy,
  output logic             seed_err
);

  localparam int CW = (DRAW > 1) ? $clog2(DRAW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             busy_q, busy_d;
  logic             seed_err_q, seed_err_d;
  logic [WIDTH-1:0] lfsr_next_s;

  // One LFSR step; an all-zero register is recovered to RESET_SEED instead.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    if (v == '0) begin
      return RESET_SEED;
    end else begin
      return {v[WIDTH-2:0], ^(v & TAPS)};
    end
  endfunction

  // Stepped LFSR value, used only in STEP.
  always_comb begin
    lfsr_next_s = lfsr_step(lfsr_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    rnd_valid_d = rnd_valid_q;
    rnd_d       = rnd_q;
    seed_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d       = 2'b00;
        rnd_valid_d = 1'b0;
        if (seed_load) begin
          // A pending req simply waits one cycle behind the load.
          if (seed == '0) begin
            lfsr_d     = RESET_SEED;
            seed_err_d = 1'b1;
          end else begin
            lfsr_d     = seed;
            seed_err_d = 1'b0;
          end
        end else if (req != 2'b00) begin
          // On a tie the requester that did not win last time goes next.
          if (req == 2'b11) begin
            id_d = ~last_q;
          end else begin
            id_d = req[1];
          end
          cnt_d   = CW'(DRAW - 1);
          state_d = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        lfsr_d = lfsr_next_s;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (req[id_q]) begin
          rnd_d       = lfsr_next_s;
          rnd_valid_d = 1'b1;
          gnt_d       = id_q ? 2'b10 : 2'b01;
          last_d      = id_q;
          state_d     = S_DONE;
        end else begin
          // Requester walked away: no pulse, but the LFSR keeps its advance.
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        gnt_d       = 2'b00;
        rnd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        gnt_d       = 2'b00;
        rnd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= RESET_SEED;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      gnt_q       <= 2'b00;
      rnd_valid_q <= 1'b0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_q       <= rnd_d;
      busy_q      <= busy_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd       = rnd_q;
  assign busy      = busy_q;
  assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_lfsr_arb.sv
// tb_lfsr_arb -- randomized self-checking bench for lfsr_arb.
// A draw-level reference model (current LFSR word, last winner, last word)
// predicts winner, word and latency of every draw.
module tb_lfsr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [3:0] seed;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rnd_valid;
  logic [3:0] rnd;
  logic       busy;
  logic       seed_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_lfsr;
  logic       m_last;
  logic [3:0] m_rnd;

  lfsr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd       (rnd),
    .busy      (busy),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  // advance a word n LFSR steps (x^4+x^3+1 feedback into the low bit)
  function automatic logic [3:0] adv(input logic [3:0] v, input int n);
    logic [3:0] w;
    w = v;
    for (int i = 0; i < n; i++) begin
      if (w == 4'd0) w = 4'b0001;
      else w = {w[2:0], 1'(($countones(w & 4'b1100)) % 2)};
    end
    return w;
  endfunction

  // model: predict winner of a request pattern
  function automatic logic [1:0] pred_gnt(input logic [1:0] r);
    if (r == 2'b11) return m_last ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr = 4'b0001;
    m_last = 1'b1;
    m_rnd  = 4'd0;
  endtask

  // apply the draw to the model
  task automatic model_draw(input logic [1:0] g);
    m_lfsr = adv(m_lfsr, 4);
    m_rnd  = m_lfsr;
    m_last = (g == 2'b10);
  endtask

  task automatic do_reset();
    req = 2'b00; seed_load = 1'b0; seed = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // perform one draw starting in IDLE; returns observed grant/word/latency
  task automatic run_draw(input logic [1:0] r, output logic [1:0] g,
                          output logic [3:0] v, output int lat, output logic got);
    req = r; lat = 0; got = 1'b0; g = 2'b00; v = 4'd0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rnd_valid) begin got = 1'b1; g = gnt; v = rnd; end
    end
    req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 2'b00; seed_load = 1'b0; seed = 4'd0;
    #12;
    checks++;
    if ({gnt, rnd_valid, rnd, busy, seed_err} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs got %b expected 0", {gnt, rnd_valid, rnd, busy, seed_err});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if ({gnt, rnd_valid, busy} !== 4'd0) begin
      errors++; $display("FAIL idle_after_reset got %b expected 0", {gnt, rnd_valid, busy});
    end
  endtask

  task automatic test_first_draw();
    logic [1:0] g; logic [3:0] v; int lat; logic got;
    req = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_step got %b expected 1", busy); end
    lat = 1;
    for (int i = 0; i < 20 && !rnd_valid; i++) begin @(posedge clk); #1; lat++; end
    g = gnt; v = rnd;
    model_draw(2'b01);
    checks++;
    if (lat !== 5 || g !== 2'b01 || v !== 4'b0011 || v !== m_rnd) begin
      errors++; $display("FAIL first_draw got lat=%0d gnt=%b rnd=%b expected lat=5 gnt=01 rnd=0011", lat, g, v);
    end
    req = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (rnd_valid !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0 || rnd !== 4'b0011) begin
      errors++; $display("FAIL pulse_end got valid=%b gnt=%b busy=%b rnd=%b expected 0 00 0 0011", rnd_valid, gnt, busy, rnd);
    end
    run_draw(2'b01, g, v, lat, got);
    model_draw(2'b01);
    checks++;
    if (!got || g !== 2'b01 || v !== 4'b0101 || v !== m_rnd) begin
      errors++; $display("FAIL second_draw got gnt=%b rnd=%b expected gnt=01 rnd=0101", g, v);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g; logic [3:0] v, e; int lat; logic got;
    for (int k = 0; k < 2; k++) begin
      e = adv(m_lfsr, 4);
      run_draw(2'b11, g, v, lat, got);
      checks++;
      if (!got || g !== (k == 0 ? 2'b10 : 2'b01) || v !== e) begin
        errors++; $display("FAIL rr_tie%0d got gnt=%b rnd=%b expected gnt=%b rnd=%b", k, g, v, (k == 0 ? 2'b10 : 2'b01), e);
      end
      model_draw(k == 0 ? 2'b10 : 2'b01);
    end
  endtask

  task automatic load_seed(input logic [3:0] s, output logic err);
    seed = s; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    err = seed_err;
    m_lfsr = (s == 4'd0) ? 4'b0001 : s;
  endtask

  task automatic test_seed();
    logic [1:0] g; logic [3:0] v; int lat; logic got, err;
    load_seed(4'b1000, err);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL seed_err_nonzero got %b expected 0", err); end
    run_draw(2'b10, g, v, lat, got);
    checks++;
    if (!got || g !== 2'b10 || v !== 4'b1001 || v !== adv(4'b1000, 4)) begin
      errors++; $display("FAIL seeded_draw got gnt=%b rnd=%b expected gnt=10 rnd=1001", g, v);
    end
    model_draw(2'b10);
    load_seed(4'b0000, err);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL seed_err_zero got %b expected 1", err); end
    @(posedge clk); #1;
    checks++;
    if (seed_err !== 1'b0) begin errors++; $display("FAIL seed_err_pulse got %b expected 0", seed_err); end
    run_draw(2'b01, g, v, lat, got);
    checks++;
    if (!got || v !== 4'b0011) begin errors++; $display("FAIL zero_seed_draw got rnd=%b expected 0011", v); end
    model_draw(2'b01);
  endtask

  task automatic test_full_period();
    logic [1:0] g; logic [3:0] v; int lat; logic got;
    logic [15:0] seen;
    int bad;
    do_reset();
    seen = 16'd0; bad = 0;
    for (int k = 0; k < 15; k++) begin
      run_draw(2'b01, g, v, lat, got);
      model_draw(2'b01);
      if (!got || v !== m_rnd || lat != 5) bad++;
      seen[v] = 1'b1;
    end
    checks++;
    if (bad != 0 || seen !== 16'hFFFE) begin
      errors++; $display("FAIL period15 got seen=%h bad=%0d expected seen=fffe bad=0", seen, bad);
    end
    run_draw(2'b01, g, v, lat, got);
    model_draw(2'b01);
    checks++;
    if (!got || v !== 4'b0011) begin errors++; $display("FAIL draw16 got rnd=%b expected 0011", v); end
  endtask

  task automatic test_abort_and_reset();
    logic [1:0] g; logic [3:0] v; int lat; logic got, pulsed;
    req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 2'b00;
    pulsed = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rnd_valid) pulsed = 1'b1; end
    m_lfsr = adv(m_lfsr, 4);
    checks++;
    if (pulsed !== 1'b0 || rnd !== m_rnd || busy !== 1'b0) begin
      errors++; $display("FAIL abort got pulsed=%b rnd=%b busy=%b expected 0 %b 0", pulsed, rnd, busy, m_rnd);
    end
    run_draw(2'b01, g, v, lat, got);
    checks++;
    if (!got || v !== adv(m_lfsr, 4)) begin
      errors++; $display("FAIL after_abort got rnd=%b expected %b", v, adv(m_lfsr, 4));
    end
    model_draw(2'b01);
    req = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, rnd_valid, rnd, busy, seed_err} !== 9'd0) begin
      errors++; $display("FAIL reset_mid_step got %b expected 0", {gnt, rnd_valid, rnd, busy, seed_err});
    end
    req = 2'b00;
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run_draw(2'b01, g, v, lat, got);
    checks++;
    if (!got || v !== 4'b0011 || g !== 2'b01) begin
      errors++; $display("FAIL draw_after_reset got gnt=%b rnd=%b expected 01 0011", g, v);
    end
    model_draw(2'b01);
  endtask

  task automatic test_load_with_req();
    int lat;
    logic [3:0] v, e;
    seed = 4'b0110; seed_load = 1'b1; req = 2'b10;
    @(posedge clk); #1;
    seed_load = 1'b0;
    lat = 1;
    for (int i = 0; i < 20 && !rnd_valid; i++) begin @(posedge clk); #1; lat++; end
    v = rnd;
    e = adv(4'b0110, 4);
    checks++;
    if (lat != 6 || v !== e || gnt !== 2'b10) begin
      errors++; $display("FAIL load_and_req got lat=%0d rnd=%b gnt=%b expected lat=6 rnd=%b gnt=10", lat, v, gnt, e);
    end
    req = 2'b00;
    @(posedge clk); #1;
    m_lfsr = 4'b0110;
    model_draw(2'b10);
  endtask

  task automatic test_random();
    logic [1:0] g, r, eg; logic [3:0] v, e, s; int lat; logic got, err;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 4'($urandom_range(0, 15));
        load_seed(s, err);
        checks++;
        if (err !== (s == 4'd0)) begin errors++; $display("FAIL rand_seed_err%0d got %b expected %b", k, err, (s == 4'd0)); end
      end
      r = 2'($urandom_range(1, 3));
      eg = pred_gnt(r);
      e = adv(m_lfsr, 4);
      run_draw(r, g, v, lat, got);
      checks++;
      if (!got || g !== eg || v !== e || lat != 5) begin
        errors++; $display("FAIL rand_draw%0d req=%b got gnt=%b rnd=%b lat=%0d expected gnt=%b rnd=%b lat=5", k, r, g, v, lat, eg, e);
      end
      model_draw(eg);
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_round_robin();
    test_seed();
    test_full_period();
    test_abort_and_reset();
    test_load_with_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
